// File: rtl/vote_ballot_box_if.sv
// Ballot-box session signals: control and buttons in, committed and live votes out.
// The master side is the session controller / button panel, the slave side is the box.
interface vote_ballot_box_if;
  logic       start;
  logic       close;
  logic [2:0] btn;
  logic [2:0] V;
  logic       v_valid;
  logic [2:0] voted;
  logic       busy;

  modport master (
    output start, close, btn,
    input  V, v_valid, voted, busy
  );

  modport slave (
    input  start, close, btn,
    output V, v_valid, voted, busy
  );
endinterface

// File: rtl/vote_ballot_box.sv
// Three-voter ballot box: synchronises and debounces yes-buttons during a timed
// session and commits the one-vote-per-voter vector V with a single-cycle strobe.
module vote_ballot_box #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WINDOW_CYCLES   = 16
) (
  input  logic              clk,
  input  logic              rst,
  vote_ballot_box_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, OPEN, CLOSE, HOLD} state_t;

  localparam logic [3:0] DB_LIMIT   = 4'(DEBOUNCE_CYCLES);
  localparam logic [3:0] DB_LAST    = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] TIMER_LOAD = 8'(WINDOW_CYCLES - 1);

  state_t     state, state_n;
  logic [2:0] sync1, sync2;
  logic [3:0] cnt   [3];
  logic [3:0] cnt_n [3];
  logic [7:0] timer, timer_n;
  logic [2:0] voted, voted_n;
  logic [2:0] v_q, v_n;
  logic       v_valid, v_valid_n;
  logic       busy, busy_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.btn;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer   <= '0;
      voted   <= '0;
      v_q     <= '0;
      v_valid <= 1'b0;
      busy    <= 1'b0;
      for (int unsigned i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      timer   <= timer_n;
      voted   <= voted_n;
      v_q     <= v_n;
      v_valid <= v_valid_n;
      busy    <= busy_n;
      for (int unsigned i = 0; i < 3; i++) cnt[i] <= cnt_n[i];
    end
  end

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    voted_n   = voted;
    v_n       = v_q;
    v_valid_n = 1'b0;
    busy_n    = busy;
    for (int unsigned i = 0; i < 3; i++) cnt_n[i] = '0;

    case (state)
      IDLE, HOLD: begin
        if (bus.start) begin
          state_n = OPEN;
          voted_n = '0;
          timer_n = TIMER_LOAD;
          busy_n  = 1'b1;
        end
      end
      OPEN: begin
        timer_n = timer - 8'd1;
        // Counter saturates at the limit; a vote maturing on the exit edge still registers.
        for (int unsigned i = 0; i < 3; i++) begin
          if (sync2[i]) begin
            cnt_n[i] = (cnt[i] == DB_LIMIT) ? cnt[i] : cnt[i] + 4'd1;
            if (cnt[i] >= DB_LAST) voted_n[i] = 1'b1;
          end
        end
        if (bus.close || timer == '0) state_n = CLOSE;
      end
      CLOSE: begin
        state_n   = HOLD;
        v_n       = voted;
        v_valid_n = 1'b1;
        busy_n    = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.V       = v_q;
  assign bus.v_valid = v_valid;
  assign bus.voted   = voted;
  assign bus.busy    = busy;

endmodule
